// File: rtl/vga_scanout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_scanout : VGA timing generator and 1-bpp front-buffer pixel reader     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module vga_scanout #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          ADDR_WIDTH = $clog2(H_ACTIVE*V_ACTIVE),
  parameter int          RD_LATENCY = 1,
  parameter logic [11:0] FG_COLOR   = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  buffer_sel,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_buf,
  input  logic                  rd_data,
  output logic                  hsync,
  output logic                  vsync,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  frame_pulse
);

  localparam int H_T = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_T = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_T);
  localparam int VW  = $clog2(V_T);

  localparam logic [HW-1:0] C_H_LAST     = HW'(H_T - 1);
  localparam logic [HW-1:0] C_H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] C_HS_FIRST   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] C_HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] C_V_LAST     = VW'(V_T - 1);
  localparam logic [VW-1:0] C_V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] C_VS_FIRST   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] C_VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [2:0]    C_PIPE_RST   = 3'b011;  // {de, hs_n, vs_n} idle

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_active;
  logic          w_hs_n;
  logic          w_vs_n;
  logic          w_frame_start;
  logic          w_vblank_start;
  logic          r_hs1;
  logic          r_vs1;
  logic [1:0]    r_bsel_sync;
  logic          r_bsel_latch;
  logic [2:0]    r_pipe [RD_LATENCY];
  logic [2:0]    w_pipe_out;
  logic [11:0]   r_rgb;

  // Stage 0: raster counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == C_H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  assign w_active       = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
  assign w_hs_n         = !((r_h_cnt >= C_HS_FIRST) && (r_h_cnt <= C_HS_LAST));
  assign w_vs_n         = !((r_v_cnt >= C_VS_FIRST) && (r_v_cnt <= C_VS_LAST));
  assign w_frame_start  = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_vblank_start = (r_h_cnt == '0) && (r_v_cnt == C_V_ACT);

  // Stage 1: read request, linear address, buffer select, frame pulse
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      r_hs1        <= 1'b1;
      r_vs1        <= 1'b1;
      frame_pulse  <= 1'b0;
      r_bsel_sync  <= 2'b00;
      r_bsel_latch <= 1'b0;
    end else begin
      rd_en       <= w_active;
      r_hs1       <= w_hs_n;
      r_vs1       <= w_vs_n;
      frame_pulse <= w_vblank_start;
      r_bsel_sync <= {r_bsel_sync[0], buffer_sel};
      if (w_frame_start) begin
        rd_addr      <= '0;
        r_bsel_latch <= r_bsel_sync[1];
      end else if (rd_en) begin
        rd_addr <= rd_addr + ADDR_WIDTH'(1);
      end
    end
  end

  // Front buffer is the one the manager is not drawing into
  assign rd_buf = ~r_bsel_latch;

  // Timing shift pipe matching the framebuffer read latency
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < RD_LATENCY; i++) r_pipe[i] <= C_PIPE_RST;
    end else begin
      r_pipe[0] <= {rd_en, r_hs1, r_vs1};
      for (int i = 1; i < RD_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_pipe_out = r_pipe[RD_LATENCY-1];

  // Output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      r_rgb <= 12'h000;
    end else begin
      hsync <= w_pipe_out[1];
      vsync <= w_pipe_out[0];
      r_rgb <= w_pipe_out[2] ? (rd_data ? FG_COLOR : BG_COLOR) : 12'h000;
    end
  end

  assign {vga_r, vga_g, vga_b} = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_scanout : scoreboard bench for vga_scanout on a reduced raster      |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_vga_scanout;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;   // 25
  localparam int VT = VA + VFP + VS + VBP;   // 11
  localparam int F  = HT * VT;               // 275 clocks per frame
  localparam int NPIX = HA * VA;             // 96
  localparam int AW = 7;
  localparam logic [11:0] FG = 12'hF5A;
  localparam logic [11:0] BG = 12'h3C1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          buffer_sel = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_buf;
  logic          rd_data = 1'b0;
  logic          hsync, vsync;
  logic [3:0]    vga_r, vga_g, vga_b;
  logic          frame_pulse;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .RD_LATENCY(1), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .resetn(resetn), .buffer_sel(buffer_sel),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_buf(rd_buf), .rd_data(rd_data),
    .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_pulse(frame_pulse)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Framebuffer model, one clock read latency
  logic mem [2**AW];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Edges since reset release; in_rst marks that the last edge saw reset
  int   k = 0;
  logic in_rst = 1'b1;
  logic started = 1'b0;
  always @(posedge clk) begin
    if (!resetn) begin
      k      <= 0;
      in_rst <= 1'b1;
    end else begin
      k      <= k + 1;
      in_rst <= 1'b0;
    end
  end

  logic [11:0] sb_q [$];

  // Expected colour pushed when a read of pixel (h,v) is due at stage 1
  always @(negedge clk) begin
    if (started) begin
      if (in_rst) sb_q.delete();
      else begin
        int p, h, v;
        p = (k - 1) % F;
        h = p % HT;
        v = p / HT;
        if (h < HA && v < VA) sb_q.push_back(mem[v*HA + h] ? FG : BG);
      end
    end
  end

  // Monitor
  logic exp_buf = 1'b1;
  int   rd_cnt = 0;
  always @(negedge clk) begin
    if (started) begin
      if (in_rst) begin
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_rgb",   32'({vga_r, vga_g, vga_b}), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_rd_buf", 32'(rd_buf), 1);
        chk("rst_frame_pulse", 32'(frame_pulse), 0);
        exp_buf = 1'b1;
        rd_cnt  = 0;
      end else begin
        int p1, h1, v1, p3, h3, v3;
        logic en1, de3;
        p1 = (k - 1) % F;
        h1 = p1 % HT;
        v1 = p1 / HT;
        en1 = (h1 < HA) && (v1 < VA);
        if (k > 1 && p1 == 0) begin
          chk("rd_en_per_frame", rd_cnt, NPIX);
          rd_cnt  = 0;
          exp_buf = ~buffer_sel;
        end
        chk("rd_en", 32'(rd_en), 32'(en1));
        if (en1) chk("rd_addr", 32'(rd_addr), v1*HA + h1);
        if (rd_en) rd_cnt++;
        chk("rd_buf", 32'(rd_buf), 32'(exp_buf));
        chk("frame_pulse", 32'(frame_pulse), (p1 == VA*HT) ? 1 : 0);
        if (k >= 3) begin
          p3 = (k - 3) % F;
          h3 = p3 % HT;
          v3 = p3 / HT;
          de3 = (h3 < HA) && (v3 < VA);
          chk("hsync", 32'(hsync), (h3 >= HA+HFP && h3 < HA+HFP+HS) ? 0 : 1);
          chk("vsync", 32'(vsync), (v3 >= VA+VFP && v3 < VA+VFP+VS) ? 0 : 1);
          if (de3) begin
            if (sb_q.size() == 0) chk("sb_empty", 1, 0);
            else chk("rgb_active", 32'({vga_r, vga_g, vga_b}), 32'(sb_q.pop_front()));
          end else begin
            chk("rgb_blank", 32'({vga_r, vga_g, vga_b}), 0);
          end
        end else begin
          chk("pipe_hsync", 32'(hsync), 1);
          chk("pipe_vsync", 32'(vsync), 1);
          chk("pipe_rgb", 32'({vga_r, vga_g, vga_b}), 0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    for (int a = 0; a < 2**AW; a++) mem[a] = a[0];
    repeat (2) step();
    started = 1'b1;
    repeat (8) step();

    // Release and time the first hsync fall and frame pulses
    @(negedge clk);
    resetn = 1'b1;
    cnt = 0;
    while (hsync === 1'b1 && cnt < 200) begin step(); cnt++; end
    chk("first_hsync_fall", cnt, HA + HFP + 3);
    while (frame_pulse !== 1'b1 && cnt < 1000) begin step(); cnt++; end
    chk("first_frame_pulse", cnt, VA*HT + 1);
    cnt = 0;
    do begin step(); cnt++; end while (frame_pulse !== 1'b1 && cnt < 1000);
    chk("frame_pulse_period", cnt, F);

    // Now at frame 1 line 6; move to frame 2 line 2 and toggle buffer_sel
    repeat (HT*(VT-VA) + 2*HT) step();
    buffer_sel = 1'b1;
    step();
    chk("rd_buf_hold", 32'(rd_buf), 1);
    cnt = 1;
    while (rd_buf !== 1'b0 && cnt < 1000) begin step(); cnt++; end
    chk("rd_buf_switch_delay", cnt, F - 2*HT);

    // Mid-frame reset at line 3, new pattern afterwards
    repeat (3*HT + 7) step();
    resetn = 1'b0;
    repeat (5) step();
    for (int a = 0; a < 2**AW; a++) mem[a] = (a % 3 == 0);
    @(negedge clk);
    resetn = 1'b1;
    cnt = 0;
    while (frame_pulse !== 1'b1 && cnt < 1000) begin step(); cnt++; end
    chk("post_reset_frame_pulse", cnt, VA*HT + 1);
    repeat (F + 20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
